dmem_sized: RTL

- Parametrised data memory for the single-cycle RISC-V core; successor to the fixed word-only dmem.
- Supports RV32I byte, halfword and word loads and stores, with sign and zero extension, driven by funct3.
- Detects misaligned and illegal accesses and suppresses the offending store; keeps a sticky fault flag and the address of the first fault.
- Optionally zero-clears the whole array after reset using an init sequencer.

---
 rtl/dmem_sized_if.sv | 29 ++
 rtl/dmem_sized.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized_if.sv
`default_nettype none
//============================================================================
// Module : dmem_sized_if
// Desc   : Access bus between the core load/store unit and dmem_sized.
// Rev    : 1.0  initial release
//============================================================================
interface dmem_sized_if;
    logic        we;
    logic        re;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        fault;
    logic [31:0] fault_addr;

    modport master (
        output we, re, funct3, a, wd,
        input  rd, ready, err, fault, fault_addr
    );

    modport slave (
        input  we, re, funct3, a, wd,
        output rd, ready, err, fault, fault_addr
    );
endinterface
`default_nettype wire

// File: rtl/dmem_sized.sv
`default_nettype none
//============================================================================
// Module : dmem_sized
// Desc   : RV32I data memory with byte/half/word access, fault capture and
//          optional zero-clear of the array after reset.
// Rev    : 1.0  initial release
//============================================================================
module dmem_sized #(
    parameter int DEPTH      = 64,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    dmem_sized_if.slave    bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] C_CNT_ONE  = 1;
    localparam logic [IDX_W-1:0] C_CNT_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_ready;
    logic              r_fault;
    logic [31:0]       r_fault_addr;
    logic [31:0]       r_mem [DEPTH];

    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic              w_is_b;
    logic              w_is_h;
    logic              w_is_w;
    logic              w_ld_illegal;
    logic              w_st_illegal;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_err;
    logic              w_wr_en;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_rd_raw;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_unused;

    // Upper address bits fold onto the array, so the memory wraps.
    assign w_idx    = bus.a[IDX_W+1:2];
    assign w_lane   = bus.a[1:0];
    assign w_unused = &{1'b0, bus.a[31:IDX_W+2]};

    //------------------------------------------------------------------------
    // Access decode and error detection
    //------------------------------------------------------------------------
    assign w_is_b       = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b100);
    assign w_is_h       = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
    assign w_is_w       = (bus.funct3 == 3'b010);
    assign w_ld_illegal = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                          (bus.funct3 == 3'b111);
    assign w_st_illegal = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
    assign w_misaligned = (w_is_h && bus.a[0]) || (w_is_w && (bus.a[1:0] != 2'b00));
    assign w_illegal    = (bus.re && w_ld_illegal) || (bus.we && w_st_illegal);
    assign w_err        = r_ready && (bus.we || bus.re) && (w_misaligned || w_illegal);
    assign w_wr_en      = bus.we && r_ready && !w_err && !reset;

    //------------------------------------------------------------------------
    // Asynchronous read path
    //------------------------------------------------------------------------
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = bus.a[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_rd_raw = '0;
        case (bus.funct3)
            3'b000:  w_rd_raw = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_rd_raw = {{16{w_half[15]}}, w_half};
            3'b010:  w_rd_raw = w_word;
            3'b100:  w_rd_raw = {24'b0, w_byte};
            3'b101:  w_rd_raw = {16'b0, w_half};
            default: w_rd_raw = '0;
        endcase
    end

    assign bus.rd = (!r_ready || w_err) ? 32'b0 : w_rd_raw;

    //------------------------------------------------------------------------
    // Store lane enables; data is replicated so each lane sees its own slice
    //------------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.wd;
        if (w_is_b) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{bus.wd[7:0]}};
        end else if (w_is_h) begin
            w_be    = bus.a[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.wd[15:0]}};
        end else if (w_is_w) begin
            w_be    = 4'b1111;
            w_wdata = bus.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_INIT)) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Reset / init / run sequencer
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RST:  w_state_nxt = INIT_CLEAR ? ST_INIT : ST_RUN;
            ST_INIT: w_state_nxt = (r_cnt == C_CNT_LAST) ? ST_RUN : ST_INIT;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RST;
            r_ready <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_RUN);
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    //------------------------------------------------------------------------
    // Sticky fault flag; only the first faulting address is kept
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else if (w_err) begin
            r_fault <= 1'b1;
            if (!r_fault) begin
                r_fault_addr <= bus.a;
            end
        end
    end

    assign bus.ready      = r_ready;
    assign bus.err        = w_err;
    assign bus.fault      = r_fault;
    assign bus.fault_addr = r_fault_addr;

endmodule
`default_nettype wire
